// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_ADDR      = 0;

  // Base bit offset of port k inside a packed bus of w-bit fields.
  function automatic int slice_base(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: array index mux, write-to-read bypass, zero-register gating
// and the per-port busy flag.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]                          i_addr,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     i_regs,
  input  logic [(2**ADDR_WIDTH)-1:0]                     i_busy,
  input  logic                                           i_we,
  input  logic [ADDR_WIDTH-1:0]                          i_waddr,
  input  logic [DATA_WIDTH-1:0]                          i_wdata,
  output logic [DATA_WIDTH-1:0]                          o_data,
  output logic                                           o_busy
);

  logic w_zero;
  logic w_hit;

  // Register 0 is gated before bypass so a discarded write never leaks out.
  assign w_zero = ZERO_REG_EN && (i_addr == ADDR_WIDTH'(ZERO_ADDR));
  assign w_hit  = BYPASS_EN && i_we && (i_waddr == i_addr) && !w_zero;

  // Select forwarded data, zero, or the stored value; a register being
  // written back this cycle is no longer reported busy when forwarding.
  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if (w_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_hit) begin
      o_data = i_wdata;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired zero register, optional
// write-to-read bypass and a per-register busy scoreboard for hazard stalls.
// No handshakes: writes and scoreboard updates take effect on the clock edge
// their strobe is high; reads are purely combinational.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_READ    = 2,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWrite,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_set_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  output logic [NUM_READ-1:0]            busy_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]                 r_busy;
  logic                             w_wr_en;
  logic                             w_set_en;

  assign w_wr_en  = RegWrite && !(ZERO_REG_EN && (write_addr == ADDR_WIDTH'(ZERO_ADDR)));
  assign w_set_en = busy_set && !(ZERO_REG_EN && (busy_set_addr == ADDR_WIDTH'(ZERO_ADDR)));

  // Array write and scoreboard update; the set is applied last so an issue
  // and a writeback to the same register leave it busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[write_addr] <= write_data;
      end
      if (RegWrite) begin
        r_busy[write_addr] <= 1'b0;
      end
      if (w_set_en) begin
        r_busy[busy_set_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG_EN(ZERO_REG_EN),
      .BYPASS_EN  (BYPASS_EN)
    ) u_port (
      .i_addr (read_addr[slice_base(k, ADDR_WIDTH) +: ADDR_WIDTH]),
      .i_regs (r_regs),
      .i_busy (r_busy),
      .i_we   (RegWrite),
      .i_waddr(write_addr),
      .i_wdata(write_data),
      .o_data (data_out[slice_base(k, DATA_WIDTH) +: DATA_WIDTH]),
      .o_busy (busy_out[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass, one without, sharing inputs.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        busy_set;
  logic [4:0]  busy_set_addr;
  logic [9:0]  read_addr;
  logic [63:0] data_out;
  logic [1:0]  busy_out;
  logic [63:0] data_out_nb;
  logic [1:0]  busy_out_nb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [65:0] exp_q[$];   // {d1, d0, b1, b0} for the bypassing instance
  logic [32:0] nb_q[$];    // {d0, b0} for the non-bypassing instance

  logic [31:0] m_regs[32];
  logic        m_busy[32];

  regfile_sb #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_addr(write_addr),
    .write_data(write_data), .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .read_addr(read_addr), .data_out(data_out), .busy_out(busy_out)
  );

  regfile_sb #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_addr(write_addr),
    .write_data(write_data), .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .read_addr(read_addr), .data_out(data_out_nb), .busy_out(busy_out_nb)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] nd0;
    logic        nb0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic bs, input logic [4:0] ba,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1,
                              input logic [31:0] nd0, input logic nb0);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.nd0 = nd0; v.nb0 = nb0;
    return v;
  endfunction

  // Reference model reads
  function automatic logic [31:0] mdl_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && RegWrite && write_addr == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic logic mdl_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && RegWrite && write_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Reference model state update at the clock edge
  task automatic mdl_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (RegWrite && write_addr != 5'd0) m_regs[write_addr] = write_data;
      if (RegWrite) m_busy[write_addr] = 1'b0;
      if (busy_set && busy_set_addr != 5'd0) m_busy[busy_set_addr] = 1'b1;
    end
  endtask

  // Driver
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic bs, input logic [4:0] ba,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; RegWrite = we; write_addr = wa; write_data = wd;
    busy_set = bs; busy_set_addr = ba; read_addr = {ra1, ra0};
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop expected values once outputs have settled mid-cycle.
  task automatic check_outputs(input string tag);
    logic [65:0] e;
    logic [32:0] n;
    #3;
    if (exp_q.size() == 0 || nb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got empty expected queue expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    n = nb_q.pop_front();
    cmp({tag, " d0"}, data_out[31:0], e[33:2]);
    cmp({tag, " d1"}, data_out[63:32], e[65:34]);
    cmp({tag, " b0"}, {31'd0, busy_out[0]}, {31'd0, e[0]});
    cmp({tag, " b1"}, {31'd0, busy_out[1]}, {31'd0, e[1]});
    cmp({tag, " nb_d0"}, data_out_nb[31:0], n[32:1]);
    cmp({tag, " nb_b0"}, {31'd0, busy_out_nb[0]}, {31'd0, n[0]});
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    mdl_edge();
  endtask

  task automatic push_model();
    exp_q.push_back({mdl_data(read_addr[9:5], 1'b1), mdl_data(read_addr[4:0], 1'b1),
                     mdl_busy(read_addr[9:5], 1'b1), mdl_busy(read_addr[4:0], 1'b1)});
    nb_q.push_back({mdl_data(read_addr[4:0], 1'b0), mdl_busy(read_addr[4:0], 1'b0)});
  endtask

  initial begin
    vec_t v;
    logic [4:0] wa, ra0, ra1;

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    end_cycle();

    // Reset then read every address on both ports
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      exp_q.push_back(66'd0);
      nb_q.push_back(33'd0);
      check_outputs($sformatf("reset_rd%0d", i));
      end_cycle();
    end

    // Directed table: inputs and hand-derived outputs during that cycle
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  5, 1,  32'hDEADBEEF, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0,  32'h1234,     0, 0,  0, 5,  32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0, 0,  32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 7,  32'h11,       0, 0,  7, 0,  32'h11, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 7,  32'h22,       0, 0,  7, 7,  32'h22, 32'h22, 0, 0, 32'h11, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  7, 5,  32'h22, 32'hDEADBEEF, 0, 0, 32'h22, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 9,  9, 9,  32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  9, 9,  32'h0, 32'h0, 1, 1, 32'h0, 1));
    vecs.push_back(mk(1, 9,  32'h99,       0, 0,  9, 5,  32'h99, 32'hDEADBEEF, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  9, 9,  32'h99, 32'h99, 0, 0, 32'h99, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 3,  3, 3,  32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 3,  32'h33,       1, 3,  3, 3,  32'h33, 32'h33, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  3, 3,  32'h33, 32'h33, 1, 1, 32'h33, 1));
    vecs.push_back(mk(0, 0,  32'h0,        1, 0,  0, 0,  32'h0, 32'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0, 3,  32'h0, 32'h33, 0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 11, 32'hAB,       1, 10, 10, 11, 32'h0, 32'hAB, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 4,  10, 11, 32'h0, 32'hAB, 1, 0, 32'h0, 1));
    vecs.push_back(mk(1, 4,  32'h44,       0, 0,  4, 10, 32'h44, 32'h0, 0, 1, 32'h0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(1'b0, v.we, v.wa, v.wd, v.bs, v.ba, v.ra0, v.ra1);
      exp_q.push_back({v.d1, v.d0, v.b1, v.b0});
      nb_q.push_back({v.nd0, v.nb0});
      check_outputs($sformatf("vec%0d", i));
      end_cycle();
    end

    // Reset mid-activity with a write and an issue in the same cycle
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd4);
    exp_q.push_back({32'h44, 32'h0, 1'b0, 1'b0});
    nb_q.push_back({32'h0, 1'b0});
    check_outputs("pre_rst");
    end_cycle();
    drive(1'b1, 1'b1, 5'd4, 32'hFF, 1'b1, 5'd6, 5'd4, 5'd6);
    #1;
    end_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6);
    exp_q.push_back(66'd0);
    nb_q.push_back(33'd0);
    check_outputs("post_rst_r4_r6");
    end_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd10);
    exp_q.push_back(66'd0);
    nb_q.push_back(33'd0);
    check_outputs("post_rst_r9_r10");
    end_cycle();

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      wa  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'b0, 1'($urandom_range(0, 1)), wa, $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)), ra0, ra1);
      push_model();
      check_outputs($sformatf("rand%0d", i));
      end_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
